mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported unified memory between the multicycle CPU datapath and the program loader/debug port. It serialises accesses, holds the address, write data and write enable stable for a fixed memory latency, and returns read data with a one-cycle acknowledge. It stalls the controller while the loader owns the memory. It sits between the datapath's memory interface (MemRead/MemWrite/IorD address) and the memory array.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-ported unified memory (CPU datapath vs loader/debug port).
// Define ARB_CPU_PRIORITY_EN for fixed CPU priority; round-robin otherwise.
module mem_port_arbiter #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ack,
   output logic                  cpu_stall,
   input  logic                  ldr_req,
   input  logic                  ldr_we,
   input  logic [ADDR_WIDTH-1:0] ldr_addr,
   input  logic [DATA_WIDTH-1:0] ldr_wdata,
   output logic                  ldr_ack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  grant_q, grant_d;
   logic                  cpu_ack_q, cpu_ack_d;
   logic                  ldr_ack_q, ldr_ack_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  win_ldr;
   logic                  issue;

   assign issue = (state_q == S_IDLE) && (cpu_req || ldr_req);

`ifdef ARB_CPU_PRIORITY_EN
   assign win_ldr = ~cpu_req;
`else
   logic last_grant_q, last_grant_d;

   // On a tie the requester not served last wins; reset value favours the CPU.
   assign win_ldr      = ldr_req & (~cpu_req | ~last_grant_q);
   assign last_grant_d = issue ? win_ldr : last_grant_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_grant_q <= 1'b1;
      else       last_grant_q <= last_grant_d;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         grant_q     <= 1'b0;
         cpu_ack_q   <= 1'b0;
         ldr_ack_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         cpu_ack_q   <= cpu_ack_d;
         ldr_ack_q   <= ldr_ack_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      cpu_ack_d   = 1'b0;
      ldr_ack_d   = 1'b0;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (issue) begin
               grant_d     = win_ldr;
               mem_en_d    = 1'b1;
               mem_we_d    = win_ldr ? ldr_we    : cpu_we;
               mem_addr_d  = win_ldr ? ldr_addr  : cpu_addr;
               mem_wdata_d = win_ldr ? ldr_wdata : cpu_wdata;
               cnt_d       = CNT_W'(MEM_LATENCY - 1);
               state_d     = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               state_d   = S_DONE;
               mem_en_d  = 1'b0;
               mem_we_d  = 1'b0;
               cpu_ack_d = ~grant_q;
               ldr_ack_d = grant_q;
               if (!mem_we_q) rdata_d = mem_rdata;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign cpu_ack   = cpu_ack_q;
   assign ldr_ack   = ldr_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rdata     = rdata_q;
   assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed transaction table, corner sequences,
// and randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 16;
   localparam int unsigned L  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, ldr_req, ldr_we;
   logic [AW-1:0] cpu_addr, ldr_addr;
   logic [DW-1:0] cpu_wdata, ldr_wdata;
   logic          cpu_ack, cpu_stall, ldr_ack;
   logic [DW-1:0] rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic          use_fixed, mem_clr;
   logic [DW-1:0] fixed_rdata;
   logic [DW-1:0] tbmem [256];

   int n_checks = 0;
   int n_pass   = 0;

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int i);
      return 32'hC0DE0000 | 32'(i);
   endfunction

   // Behavioural memory array behind the arbiter.
   assign mem_rdata = use_fixed ? fixed_rdata : tbmem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (mem_clr) for (int i = 0; i < 256; i++) tbmem[i] <= init_val(i);
      else if (mem_en && mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic          is_ldr;
      logic          we;
      logic [AW-1:0] addr;
      logic [AW-1:0] mid_addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] mem_val;
      logic [DW-1:0] exp_rdata;
   } txn_t;

   // One complete transaction; entered and left at #1 after an edge with the FSM idle.
   task automatic run_txn(input txn_t t);
      fixed_rdata = t.mem_val;
      if (t.is_ldr) begin
         ldr_req = 1'b1; ldr_we = t.we; ldr_addr = t.addr; ldr_wdata = t.wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata;
      end
      for (int k = 1; k <= int'(L); k++) begin
         @(posedge clk); #1;
         check("acc_en",   64'(mem_en),   64'(1));
         check("acc_we",   64'(mem_we),   64'(t.we));
         check("acc_addr", 64'(mem_addr), 64'(t.addr));
         if (t.we) check("acc_wdata", 64'(mem_wdata), 64'(t.wdata));
         check("acc_cpu_ack", 64'(cpu_ack), 64'(0));
         check("acc_ldr_ack", 64'(ldr_ack), 64'(0));
         if (!t.is_ldr) check("acc_stall", 64'(cpu_stall), 64'(1));
         if (k == 1) begin
            if (t.is_ldr) ldr_addr = t.mid_addr;
            else          cpu_addr = t.mid_addr;
         end
      end
      @(posedge clk); #1;
      check("done_en",      64'(mem_en),    64'(0));
      check("done_cpu_ack", 64'(cpu_ack),   64'(!t.is_ldr));
      check("done_ldr_ack", 64'(ldr_ack),   64'(t.is_ldr));
      check("done_rdata",   64'(rdata),     64'(t.exp_rdata));
      check("done_stall",   64'(cpu_stall), 64'(0));
      cpu_req = 1'b0;
      ldr_req = 1'b0;
      @(posedge clk); #1;
      check("post_cpu_ack", 64'(cpu_ack), 64'(0));
      check("post_ldr_ack", 64'(ldr_ack), 64'(0));
      check("post_rdata",   64'(rdata),   64'(t.exp_rdata));
   endtask

   txn_t tbl [4];

   // Reference model state (transaction timeline).
   int            m_busy;
   logic          m_last, m_grant, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [DW-1:0] model_mem [256];

   initial begin
      logic exp_cpu, exp_ldr, wl;
      int   n_acks;

      tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h00FF, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[1] = '{1'b1, 1'b1, 16'h0004, 16'h0044, 32'h12345678, 32'h11111111, 32'hDEADBEEF};
      tbl[2] = '{1'b0, 1'b1, 16'h00A0, 16'h00A1, 32'hCAFEF00D, 32'h22222222, 32'hDEADBEEF};
      tbl[3] = '{1'b1, 1'b0, 16'h0020, 16'h0021, 32'h00000000, 32'h0BADF00D, 32'h0BADF00D};

      reset = 1'b1; use_fixed = 1'b1; mem_clr = 1'b0; fixed_rdata = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_en",    64'(mem_en),    64'(0));
      check("rst_mem_we",    64'(mem_we),    64'(0));
      check("rst_cpu_ack",   64'(cpu_ack),   64'(0));
      check("rst_ldr_ack",   64'(ldr_ack),   64'(0));
      check("rst_mem_addr",  64'(mem_addr),  64'(0));
      check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      check("rst_rdata",     64'(rdata),     64'(0));
      check("rst_stall",     64'(cpu_stall), 64'(0));
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) run_txn(tbl[i]);

      // Both requesters held continuously from reset release.
      reset = 1'b1;
      cpu_req = 1'b1; ldr_req = 1'b1; cpu_we = 1'b0; ldr_we = 1'b0;
      cpu_addr = 16'h0001; ldr_addr = 16'h0002; fixed_rdata = 32'h0000AAAA;
      @(negedge clk) reset = 1'b0;
      n_acks = 0;
      for (int n = 1; n <= 16; n++) begin
         @(posedge clk); #1;
`ifdef ARB_CPU_PRIORITY_EN
         exp_cpu = (n % 4 == 3);
`else
         exp_cpu = (n % 4 == 3) && (((n - 3) / 4) % 2 == 0);
`endif
         exp_ldr = (n % 4 == 3) && !exp_cpu;
         check("both_cpu_ack", 64'(cpu_ack), 64'(exp_cpu));
         check("both_ldr_ack", 64'(ldr_ack), 64'(exp_ldr));
         if (cpu_ack || ldr_ack) n_acks++;
      end
      check("both_ack_count", 64'(n_acks), 64'(4));
      cpu_req = 1'b0; ldr_req = 1'b0;
      @(posedge clk); #1;

      // Reset during the first ACCESS cycle of a CPU read.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030; fixed_rdata = 32'h55555555;
      @(posedge clk); #1;
      check("abort_pre_en", 64'(mem_en), 64'(1));
      reset = 1'b1;
      #1;
      check("abort_en",    64'(mem_en),   64'(0));
      check("abort_addr",  64'(mem_addr), 64'(0));
      check("abort_rdata", 64'(rdata),    64'(0));
      cpu_req = 1'b0;
      @(negedge clk) reset = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         check("abort_no_ack", 64'(cpu_ack), 64'(0));
         check("abort_idle_en", 64'(mem_en), 64'(0));
      end
      run_txn(tbl[0]);

      // Randomized traffic against the reference model.
      reset = 1'b1; mem_clr = 1'b1; use_fixed = 1'b0;
      @(posedge clk); #1;
      mem_clr = 1'b0;
      for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
      m_busy = 0; m_last = 1'b1; m_grant = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      @(negedge clk) reset = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk);
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 1 && !m_we) m_rdata = model_mem[m_addr[7:0]];
         end else if (cpu_req || ldr_req) begin
`ifdef ARB_CPU_PRIORITY_EN
            wl = !cpu_req;
`else
            wl = (cpu_req && ldr_req) ? !m_last : ldr_req;
`endif
            m_last  = wl;
            m_grant = wl;
            m_we    = wl ? ldr_we    : cpu_we;
            m_addr  = wl ? ldr_addr  : cpu_addr;
            m_wdata = wl ? ldr_wdata : cpu_wdata;
            if (m_we) model_mem[m_addr[7:0]] = m_wdata;
            m_busy = int'(L) + 1;
         end
         #1;
         exp_cpu = (m_busy == 1) && !m_grant;
         exp_ldr = (m_busy == 1) &&  m_grant;
         check("rnd_en", 64'(mem_en), 64'(m_busy >= 2));
         if (m_busy >= 2) begin
            check("rnd_we",    64'(mem_we),    64'(m_we));
            check("rnd_addr",  64'(mem_addr),  64'(m_addr));
            check("rnd_wdata", 64'(mem_wdata), 64'(m_wdata));
         end
         check("rnd_cpu_ack", 64'(cpu_ack),   64'(exp_cpu));
         check("rnd_ldr_ack", 64'(ldr_ack),   64'(exp_ldr));
         check("rnd_rdata",   64'(rdata),     64'(m_rdata));
         check("rnd_stall",   64'(cpu_stall), 64'(cpu_req && !exp_cpu));
         cpu_req   = ($urandom % 4) != 0;
         cpu_we    = 1'($urandom % 2);
         cpu_addr  = 16'($urandom_range(0, 15));
         cpu_wdata = $urandom;
         ldr_req   = ($urandom % 4) != 0;
         ldr_we    = 1'($urandom % 2);
         ldr_addr  = 16'($urandom_range(0, 15));
         ldr_wdata = $urandom;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
